// File: rtl/cicero_mem_pkg.sv
// Shared types and width helpers for the cache miss refill responder.
// Default-configuration widths are exported alongside functions that derive them for any configuration.
package cicero_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } refill_state_t;

    localparam int DWIDTH_DEF           = 4;
    localparam int BLOCK_WIDTH_BITS_DEF = 4;
    localparam int ADDR_IN_WIDTH_DEF    = 16;

    function automatic int req_addr_width(input int addr_in_width, input int block_width_bits);
        return addr_in_width - block_width_bits;
    endfunction

    function automatic int line_width(input int dwidth, input int block_width_bits);
        return dwidth * (2 ** block_width_bits);
    endfunction

    // A one-word line still needs a 1-bit word index to keep port widths legal.
    function automatic int idx_width(input int block_width_bits);
        return (block_width_bits > 0) ? block_width_bits : 1;
    endfunction

    localparam int REQ_ADDR_WIDTH = req_addr_width(ADDR_IN_WIDTH_DEF, BLOCK_WIDTH_BITS_DEF);
    localparam int LINE_WIDTH     = line_width(DWIDTH_DEF, BLOCK_WIDTH_BITS_DEF);

endpackage

// File: rtl/refill_line_buffer.sv
// Line register with word-indexed write, plus the optional last-line reuse entry.
// REFILL_LINE_REUSE_EN adds a block-address/valid entry and a lookup hit output.
module refill_line_buffer
    import cicero_mem_pkg::*;
#(
    parameter int DWIDTH           = DWIDTH_DEF,
    parameter int BLOCK_WIDTH_BITS = BLOCK_WIDTH_BITS_DEF,
    parameter int RA_W             = REQ_ADDR_WIDTH,
    parameter int LINE_W           = LINE_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [idx_width(BLOCK_WIDTH_BITS)-1:0] wr_idx,
    input  logic [DWIDTH-1:0]                      wr_data,
    input  logic                                   entry_wr,
    input  logic [RA_W-1:0]                        entry_addr,
    input  logic [RA_W-1:0]                        lookup_addr,
    output logic                                   hit,
    output logic [LINE_W-1:0]                      line
);

    localparam int BLOCK_WIDTH = 2 ** BLOCK_WIDTH_BITS;
    localparam int IDX_W       = idx_width(BLOCK_WIDTH_BITS);

    logic [LINE_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (wr_en) begin
            for (int i = 0; i < BLOCK_WIDTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    line_d[i*DWIDTH +: DWIDTH] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

`ifdef REFILL_LINE_REUSE_EN
    // The line register itself is the stored line; only its tag needs keeping.
    logic            entry_v_q, entry_v_d;
    logic [RA_W-1:0] entry_addr_q, entry_addr_d;

    always_comb begin
        entry_v_d    = entry_v_q;
        entry_addr_d = entry_addr_q;
        if (entry_wr) begin
            entry_v_d    = 1'b1;
            entry_addr_d = entry_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_v_q    <= 1'b0;
            entry_addr_q <= '0;
        end else begin
            entry_v_q    <= entry_v_d;
            entry_addr_q <= entry_addr_d;
        end
    end

    assign hit = entry_v_q && (entry_addr_q == lookup_addr);
`else
    logic unused_reuse;
    assign unused_reuse = ^{entry_wr, entry_addr, lookup_addr};
    assign hit          = 1'b0;
`endif

endmodule

// File: rtl/cache_block_refill_responder.sv
// Refills one cache line from a word-wide backing memory and answers with a one-cycle ready pulse.
// Optional last-line reuse is enabled by REFILL_LINE_REUSE_EN.
//
//  state  | meaning
//  S_IDLE | waiting for a miss request; memory responses ignored
//  S_FILL | issuing word reads back-to-back and collecting in-order responses
//  S_RESP | line complete; req_ready high for this single cycle
module cache_block_refill_responder
    import cicero_mem_pkg::*;
#(
    parameter int DWIDTH           = DWIDTH_DEF,
    parameter int BLOCK_WIDTH_BITS = BLOCK_WIDTH_BITS_DEF,
    parameter int ADDR_IN_WIDTH    = ADDR_IN_WIDTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req_valid,
    input  logic [ADDR_IN_WIDTH-BLOCK_WIDTH_BITS-1:0]  req_addr,
    output logic                                       req_ready,
    output logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]    line_data,
    output logic                                       mem_req_valid,
    output logic [ADDR_IN_WIDTH-1:0]                   mem_addr,
    input  logic                                       mem_req_ready,
    input  logic                                       mem_rsp_valid,
    input  logic [DWIDTH-1:0]                          mem_rsp_data
);

    localparam int BLOCK_WIDTH = 2 ** BLOCK_WIDTH_BITS;
    localparam int RA_W        = req_addr_width(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS);
    localparam int LINE_W      = line_width(DWIDTH, BLOCK_WIDTH_BITS);
    localparam int CNT_W       = BLOCK_WIDTH_BITS + 1;
    localparam int IDX_W       = idx_width(BLOCK_WIDTH_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WIDTH);

    refill_state_t    state_q, state_d;
    logic [RA_W-1:0]  req_addr_q, req_addr_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic             req_ready_q, req_ready_d;

    logic reuse_hit;
    logic issue_take;
    logic rsp_take;
    logic entry_wr;

    assign mem_req_valid = (state_q == S_FILL) && (issue_cnt_q < CNT_FULL);
    assign issue_take    = mem_req_valid && mem_req_ready;
    assign rsp_take      = (state_q == S_FILL) && mem_rsp_valid && (rsp_cnt_q < CNT_FULL);

    generate
        if (BLOCK_WIDTH_BITS > 0) begin : g_word_idx
            assign mem_addr = {req_addr_q, issue_cnt_q[BLOCK_WIDTH_BITS-1:0]};
        end else begin : g_single_word
            assign mem_addr = req_addr_q;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_addr_d  = req_addr;
                    issue_cnt_d = '0;
                    rsp_cnt_d   = '0;
                    state_d     = reuse_hit ? S_RESP : S_FILL;
                end
            end
            S_FILL: begin
                if (issue_take) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (rsp_take) begin
                    rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
                end
                // Leave on the same edge the last word is written.
                if (rsp_cnt_d == CNT_FULL) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_RESP);
    end

    assign entry_wr = (state_q == S_FILL) && (state_d == S_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;

    refill_line_buffer #(
        .DWIDTH           (DWIDTH),
        .BLOCK_WIDTH_BITS (BLOCK_WIDTH_BITS),
        .RA_W             (RA_W),
        .LINE_W           (LINE_W)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (rsp_take),
        .wr_idx      (rsp_cnt_q[IDX_W-1:0]),
        .wr_data     (mem_rsp_data),
        .entry_wr    (entry_wr),
        .entry_addr  (req_addr_q),
        .lookup_addr (req_addr),
        .hit         (reuse_hit),
        .line        (line_data)
    );

endmodule

// File: tb/tb_cache_block_refill_responder.sv
// Self-checking bench: transaction-level model of the refill responder plus an in-order memory with latency.
module tb_cache_block_refill_responder;

    localparam int BW = 16;

`ifdef REFILL_LINE_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_ready;
    logic [63:0] line_data;
    logic        mem_req_valid;
    logic [15:0] mem_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [3:0]  mem_rsp_data;

    always #5 clk = ~clk;

    cache_block_refill_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .line_data     (line_data),
        .mem_req_valid (mem_req_valid),
        .mem_addr      (mem_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {int due; logic [3:0] d;} rsp_t;
    rsp_t rq[$];
    int   lat       = 1;
    int   ready_pct = 100;
    bit   hash_mode = 1'b0;

    // model of what the block must be doing
    bit          m_fill = 1'b0;
    int          m_issued, m_got;
    logic [11:0] m_blk;
    int          m_rdy_due = -10;
    logic [63:0] m_line_exp;
    logic [63:0] m_line = '0;
    bit          m_ent_v = 1'b0;
    logic [11:0] m_ent_a;

    int n_acc = 0, n_done = 0, n_valid_cycles = 0;
    int last_T = 0, last_rdy_cyc = 0;
    logic [15:0] acc_a[$];
    int          acc_c[$];
    int          rdy_log[$];

    bit          rst_req = 1'b0;
    int          rst_hold = 0;
    bit          req_pend = 1'b0;
    logic [11:0] pend_addr;
    bit          chain_v = 1'b0;
    logic [11:0] chain_a;
    bit          arm_mid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] memf(input logic [15:0] a);
        int s;
        if (!hash_mode) return a[3:0];
        s = a[3:0] + 3 * a[7:4] + 5 * a[11:8] + 7 * a[15:12] + 1;
        return s[3:0];
    endfunction

    function automatic logic [63:0] line_of(input logic [11:0] b);
        logic [63:0] ln;
        for (int i = 0; i < BW; i++) ln[i*4 +: 4] = memf({b, 4'(i)});
        return ln;
    endfunction

    task automatic tick();
        bit idle;
        @(negedge clk);
        cyc++;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst = 1'b1;
        end
        if (rst_req) begin
            rst_req   = 1'b0;
            rst       = 1'b0;
            rst_hold  = 2;
            req_valid = 1'b0;
            req_pend  = 1'b0;
            chain_v   = 1'b0;
            #1;
            check("rst_req_ready", req_ready, 1'b0);
            check("rst_mem_req_valid", mem_req_valid, 1'b0);
            check("rst_mem_addr", mem_addr, 16'h0000);
            check("rst_line_data", line_data, 64'h0);
            m_fill = 1'b0; m_rdy_due = -10; m_line = '0; m_ent_v = 1'b0;
        end
        if (rst) begin
            check("req_ready", req_ready, cyc == m_rdy_due);
            check("mem_req_valid", mem_req_valid, m_fill && m_issued < BW);
            if (m_fill && m_issued < BW) check("mem_addr", mem_addr, {m_blk, 4'(m_issued)});
            check("line_data", line_data, m_line);
            if (cyc == m_rdy_due || cyc == m_rdy_due + 1) check("line_at_ready", line_data, m_line_exp);
            if (req_ready) begin n_done++; last_rdy_cyc = cyc; rdy_log.push_back(cyc); end
            if (mem_req_valid) n_valid_cycles++;
        end
        // memory side
        mem_req_ready = ($urandom_range(99) < ready_pct);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rq[0].d;
            rq.delete(0);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 4'($urandom);
        end
        // cache side
        if (rst && req_ready && req_valid) begin
            if (chain_v) begin req_addr = chain_a; chain_v = 1'b0; end
            else req_valid = 1'b0;
        end
        if (req_pend) begin req_valid = 1'b1; req_addr = pend_addr; req_pend = 1'b0; end
        idle = rst && !m_fill && (cyc != m_rdy_due);
        if (rst && mem_req_valid && mem_req_ready) begin
            rq.push_back('{cyc + lat, memf(mem_addr)});
            n_acc++;
            acc_a.push_back(mem_addr);
            acc_c.push_back(cyc);
        end
        if (rst && m_fill && m_issued < BW && mem_req_ready) m_issued++;
        if (rst && m_fill && mem_rsp_valid && m_got < BW) begin
            m_line[m_got*4 +: 4] = mem_rsp_data;
            m_got++;
            if (m_got == BW) begin
                m_fill = 1'b0; m_rdy_due = cyc + 1; m_ent_v = 1'b1; m_ent_a = m_blk;
            end
            if (arm_mid && m_got == 5) begin rst_req = 1'b1; arm_mid = 1'b0; end
        end
        if (idle && req_valid) begin
            last_T     = cyc;
            m_blk      = req_addr;
            m_line_exp = line_of(req_addr);
            if (REUSE && m_ent_v && m_ent_a == req_addr) m_rdy_due = cyc + 1;
            else begin m_fill = 1'b1; m_issued = 0; m_got = 0; end
        end
    endtask

    task automatic do_request(input logic [11:0] a, input bit chain, input logic [11:0] ca);
        int target, budget;
        target    = n_done + (chain ? 2 : 1);
        req_pend  = 1'b1;
        pend_addr = a;
        chain_v   = chain;
        chain_a   = ca;
        budget    = 600;
        while (n_done < target && budget > 0) begin tick(); budget--; end
        check("req_done", n_done >= target, 1'b1);
    endtask

    task automatic pulse_reset();
        rst_req = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        int v0, a0, budget;
        logic [11:0] pool[4];
        req_valid = 1'b0; req_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        pool[0] = 12'h012; pool[1] = 12'h013; pool[2] = 12'h7A5; pool[3] = 12'hFFF;

        pulse_reset();

        // directed fill, ready always high, L=1
        acc_a.delete(); acc_c.delete();
        do_request(12'h012, 1'b0, '0);
        check("dir_issue_count", acc_a.size(), 16);
        for (int i = 0; i < acc_a.size(); i++) begin
            check("dir_addr", acc_a[i], 16'h0120 + 16'(i));
            check("dir_issue_cycle", acc_c[i] - last_T, 1 + i);
        end
        check("dir_ready_latency", last_rdy_cyc - last_T, 18);
        check("dir_line", line_data, 64'hFEDCBA9876543210);
        tick();
        check("dir_line_hold", line_data, 64'hFEDCBA9876543210);

        // repeat the same block
        v0 = n_valid_cycles;
        do_request(12'h012, 1'b0, '0);
        check("repeat_latency", last_rdy_cyc - last_T, REUSE ? 1 : 18);
        check("repeat_mem_cycles", n_valid_cycles - v0, REUSE ? 0 : 16);

        // random stalls
        pulse_reset();
        ready_pct = 50; lat = 2; a0 = n_acc;
        do_request(12'h012, 1'b0, '0);
        check("stall_accepted", n_acc - a0, 16);
        check("stall_line", line_data, 64'hFEDCBA9876543210);

        // back-to-back with req_valid held through the ready cycle
        pulse_reset();
        ready_pct = 100; lat = 1; a0 = n_acc;
        acc_c.delete(); rdy_log.delete();
        do_request(12'h012, 1'b1, 12'h013);
        check("b2b_accepted", n_acc - a0, 32);
        if (acc_c.size() == 32 && rdy_log.size() >= 1)
            check("b2b_second_start", acc_c[16] - rdy_log[0], 2);
        else
            check("b2b_logs", acc_c.size(), 32);
        tick();
        check("b2b_line_hold", line_data, 64'hFEDCBA9876543210);

        // reset in the middle of a fill
        pulse_reset();
        lat = 3; arm_mid = 1'b1;
        req_pend = 1'b1; pend_addr = 12'h0AB; chain_v = 1'b0;
        budget = 200;
        while (rst && budget > 0) begin tick(); budget--; end
        check("mid_reset_taken", rst, 1'b0);
        budget = 200;
        while ((rq.size() > 0 || !rst) && budget > 0) begin tick(); budget--; end
        check("late_rsp_ignored_line", line_data, 64'h0);
        check("late_rsp_no_ready", req_ready, 1'b0);
        lat = 1;
        do_request(12'h001, 1'b0, '0);
        check("post_reset_line", line_data, 64'hFEDCBA9876543210);

        // randomized traffic with hashed memory contents
        pulse_reset();
        hash_mode = 1'b1;
        for (int it = 0; it < 60; it++) begin
            logic [11:0] a, b;
            bit ch;
            ready_pct = $urandom_range(100, 30);
            lat       = $urandom_range(4, 1);
            a  = ($urandom_range(4) == 4) ? 12'($urandom) : pool[$urandom_range(3)];
            b  = pool[$urandom_range(3)];
            ch = ($urandom_range(3) == 0);
            do_request(a, ch, b);
            for (int g = 0; g < int'($urandom_range(3)); g++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_block_refill_responder.md
# cache_block_refill_responder

Memory-side responder for the directly-mapped block cache's miss interface. It accepts a block address from a cache and fetches the block's words from a narrow, word-addressed backing memory, issuing requests back-to-back. It assembles the words into one cache line and answers with a single-cycle ready pulse, holding the line stable for the cache to capture. It sits between each basic block's cache and the shared instruction memory port.

## Interface
- `DWIDTH`, 4, bits per memory word.
- `BLOCK_WIDTH_BITS`, 4, log2 of words per line; `BLOCK_WIDTH = 2**BLOCK_WIDTH_BITS`.
- `ADDR_IN_WIDTH`, 16, word-address width; `REQ_ADDR_WIDTH = ADDR_IN_WIDTH-BLOCK_WIDTH_BITS`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: cache miss request.
- `req_addr` in REQ_ADDR_WIDTH: block address; stable while `req_valid` is high until `req_ready`.
- `req_ready` out 1: one-cycle pulse; the line is complete.
- `line_data` out DWIDTH*BLOCK_WIDTH: assembled line; word i at bits [i*DWIDTH +: DWIDTH].
- `mem_req_valid` out 1: word read request.
- `mem_addr` out ADDR_IN_WIDTH: `{req_addr_saved, issue_idx}`.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_rsp_valid` in 1: read data returned. Responses are in order and cannot be backpressured.
- `mem_rsp_data` in DWIDTH: read word.

## Operation
- FSM states: S_IDLE, S_FILL, S_RESP.
- **S_IDLE**
  - `req_valid`=1: latch `req_addr`, clear `issue_cnt` and `rsp_cnt`, go to S_FILL.
  - `mem_rsp_valid` is ignored.
- **S_FILL**
  - `mem_req_valid`=1 while `issue_cnt`<BLOCK_WIDTH. `issue_cnt` increments on `mem_req_valid && mem_req_ready`.
  - Each `mem_rsp_valid` writes `mem_rsp_data` to line word `rsp_cnt`, then `rsp_cnt` increments.
  - An issue and a response in the same cycle are both counted.
  - Go to S_RESP when `rsp_cnt` reaches BLOCK_WIDTH. This includes the cycle the last response lands.
- **S_RESP**
  - `req_ready`=1 for exactly one cycle, then go to S_IDLE.
  - `req_valid` is ignored in this cycle, so there is no re-trigger.
- `line_data` holds its value from S_RESP until the first response of the next fill. The cache therefore captures it the cycle after `req_ready`.
- Counters are BLOCK_WIDTH_BITS+1 bits wide. `issue_idx = issue_cnt[BLOCK_WIDTH_BITS-1:0]`.
- Spurious `mem_rsp_valid` with `rsp_cnt`==BLOCK_WIDTH is dropped.
- BLOCK_WIDTH_BITS=0 is legal: a one-word line, one request.

## Timing
- Reset values:
  - `req_ready`=0, `mem_req_valid`=0, `mem_addr`=0, `line_data`=0.
  - State S_IDLE, counters 0.
  - Reuse entry invalid (when enabled).
- `req_valid` seen at cycle T:
  - First `mem_req_valid` at T+1.
  - With `mem_req_ready` held at 1, word i is issued at T+1+i.
  - With response latency L, the last response arrives at T+BLOCK_WIDTH+L and `req_ready` pulses at T+BLOCK_WIDTH+L+1.
- `mem_req_ready`=0 stalls issue; `mem_addr` and `mem_req_valid` are held.
- Reset asserted mid-fill: immediate return to reset values. The memory must be reset with the block; in-flight responses that arrive afterwards land in S_IDLE and are ignored.
- All outputs are registered except `mem_addr` and `mem_req_valid`, which are decoded from registered state and counters.

## Configuration
- `REFILL_LINE_REUSE_EN` defined:
  - The block keeps the last completed line plus its block address and a valid bit.
  - In S_IDLE, `req_valid` with a matching valid address goes straight to S_RESP: `req_ready` at T+1, no memory traffic.
  - The entry is updated at each S_RESP reached through S_FILL, and cleared by reset.
- `REFILL_LINE_REUSE_EN` undefined: every request performs a full fill.

## Structure
- Shared package `cicero_mem_pkg` holds:
  - the state typedef (`refill_state_t`: S_IDLE, S_FILL, S_RESP);
  - the derived-width localparams (REQ_ADDR_WIDTH, LINE_WIDTH).
- One natural sub-module, `refill_line_buffer`: line register with word-indexed write, plus the optional reuse address/valid compare.
- The FSM and counters stay in the top module.

## Test plan
- Default params, memory with `mem_req_ready`=1, L=1, word a holds a[3:0]; request `req_addr`=0x012:
  - `mem_addr` runs 0x0120..0x012F on consecutive cycles;
  - `req_ready` pulses at T+18;
  - `line_data`=0xFEDCBA9876543210.
- Random `mem_req_ready` stalls (50%): `mem_addr` held during each stall, same `line_data`, exactly 16 accepted requests.
- Back-to-back requests 0x012 then 0x013 with `req_valid` high during S_RESP:
  - exactly two fills;
  - the second starts only after S_IDLE;
  - `line_data` is unchanged in the cycle after each `req_ready`.
- Assert `rst`=0 at the 5th response of a fill:
  - outputs return to reset values immediately;
  - late responses are ignored;
  - a new request 0x001 completes correctly.
- With `REFILL_LINE_REUSE_EN`, repeat 0x012: `req_ready` at T+1, zero `mem_req_valid` cycles. Without the macro, the same stimulus causes a full 16-word fill.
